// File: rtl/datamem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : datamem_pkg
// Brief    : Shared types, transfer-size codes and size helper for the
//            data-memory responder.
// Revision : 1.0 - initial release
// ============================================================================
package datamem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } dm_state_t;

  localparam logic [3:0] SZ_B = 4'd1;
  localparam logic [3:0] SZ_H = 4'd2;
  localparam logic [3:0] SZ_W = 4'd4;
  localparam logic [3:0] SZ_D = 4'd8;

  // A transfer size is legal only for byte, half, word and double.
  function automatic logic size_legal(input logic [3:0] size);
    return (size == SZ_B) || (size == SZ_H) || (size == SZ_W) || (size == SZ_D);
  endfunction

endpackage
`default_nettype wire

// File: rtl/datamem_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : datamem_lane_align
// Brief    : Big-endian lane shifter for one 8-byte memory word. Word bit
//            lanes hold mem[base+0] in [63:56] down to mem[base+7] in [7:0];
//            byte_en[j] selects word bits [8j+7:8j].
// Revision : 1.0 - initial release
// ============================================================================
module datamem_lane_align
  import datamem_pkg::*;
(
  input  logic [2:0]  offset,
  input  logic [3:0]  size,
  input  logic [63:0] wdata,
  input  logic [63:0] rword,
  output logic [7:0]  byte_en,
  output logic [63:0] wword,
  output logic [63:0] rfield
);

  logic [7:0]  mask8;
  logic [63:0] mask64;
  logic [2:0]  sh;

  // Field sits (8 - offset - size) bytes above the word LSB; illegal sizes give an empty mask.
  always_comb begin
    mask8 = 8'h00;
    case (size)
      SZ_B:    mask8 = 8'h01;
      SZ_H:    mask8 = 8'h03;
      SZ_W:    mask8 = 8'h0F;
      SZ_D:    mask8 = 8'hFF;
      default: mask8 = 8'h00;
    endcase
    sh     = 3'd0 - offset - size[2:0];
    mask64 = '0;
    for (int j = 0; j < 8; j++) begin
      mask64[8*j +: 8] = {8{mask8[j]}};
    end
    byte_en = mask8 << sh;
    wword   = (wdata & mask64) << {sh, 3'b000};
    rfield  = (rword >> {sh, 3'b000}) & mask64;
  end

endmodule
`default_nettype wire

// File: rtl/datamem_responder.sv
`default_nettype none
// ============================================================================
// Module   : datamem_responder
// Brief    : Fixed-latency big-endian data-memory responder with valid/ready
//            request and response channels and illegal-access flagging.
// Revision : 1.0 - initial release
// ============================================================================
module datamem_responder
  import datamem_pkg::*;
#(
  parameter int MEM_BYTES = 1024,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_addr,
  input  logic        req_write,
  input  logic [63:0] req_wdata,
  input  logic [3:0]  req_size,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        resp_write
);

  localparam int AW = $clog2(MEM_BYTES);

  dm_state_t   state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] addr_q, addr_d;
  logic        write_q, write_d;
  logic [63:0] wdata_q, wdata_d;
  logic [3:0]  size_q, size_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic [63:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;
  logic        resp_write_q, resp_write_d;
  logic        mem_we;

  logic [7:0]  mem [0:MEM_BYTES-1];
  logic [63:0] rword;
  logic [7:0]  byte_en;
  logic [63:0] wword;
  logic [63:0] rfield;
  logic        access_err;

  // Gather the 8-byte word containing the captured address, MSB lane first.
  for (genvar k = 0; k < 8; k++) begin : g_rd_lane
    assign rword[63-8*k -: 8] = mem[{addr_q[AW-1:3], 3'(k)}];
  end

  datamem_lane_align u_lane_align (
    .offset  (addr_q[2:0]),
    .size    (size_q),
    .wdata   (wdata_q),
    .rword   (rword),
    .byte_en (byte_en),
    .wword   (wword),
    .rfield  (rfield)
  );

  // Illegal size, misalignment, or a field running past the array end (no 64-bit wrap).
  always_comb begin
    access_err = !size_legal(size_q)
              || ((addr_q[2:0] & (size_q[2:0] - 3'd1)) != 3'd0)
              || (({1'b0, addr_q} + {61'b0, size_q}) > 65'(MEM_BYTES));
  end

  // Next-state logic; LATENCY==1 simply spends one BUSY cycle with the counter already at zero.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    write_d      = write_q;
    wdata_d      = wdata_q;
    size_d       = size_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    resp_write_d = resp_write_q;
    mem_we       = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          addr_d      = req_addr;
          write_d     = req_write;
          wdata_d     = req_wdata;
          size_d      = req_size;
          cnt_d       = 4'(LATENCY - 1);
          state_d     = BUSY;
          req_ready_d = 1'b0;
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d      = RESP;
          mem_we       = write_q && !access_err;
          resp_valid_d = 1'b1;
          resp_err_d   = access_err;
          resp_write_d = write_q;
          resp_rdata_d = (write_q || access_err) ? 64'd0 : rfield;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d      = IDLE;
          req_ready_d  = 1'b1;
          resp_valid_d = 1'b0;
          resp_rdata_d = 64'd0;
          resp_err_d   = 1'b0;
          resp_write_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and response registers; reset discards any in-flight request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      addr_q       <= 64'd0;
      write_q      <= 1'b0;
      wdata_q      <= 64'd0;
      size_q       <= 4'd0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 64'd0;
      resp_err_q   <= 1'b0;
      resp_write_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      write_q      <= write_d;
      wdata_q      <= wdata_d;
      size_q       <= size_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      resp_write_q <= resp_write_d;
    end
  end

  // Backing store has no reset; stores commit byte-by-byte on the access edge.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int k = 0; k < 8; k++) begin
        if (byte_en[7-k]) begin
          mem[{addr_q[AW-1:3], 3'(k)}] <= wword[63-8*k -: 8];
        end
      end
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign resp_write = resp_write_q;

endmodule
`default_nettype wire
